multdiv32: RTL and testbench
============================

MULTDIV32 -- requirements
Module: multdiv32

Interface
REQ-001 SHALL have port: clock  input  1  single clock, all state updates on rising edge.
REQ-002 SHALL have port: reset  input  1  asynchronous, active-low reset.
REQ-003 SHALL have port: start  input  1  request strobe from execute stage, sampled each rising edge.
REQ-004 SHALL have port: Function_opcode  input  6  instruction[5:0]: mult 011000, multu 011001, div 011010, divu 011011, mthi 010001, mtlo 010011.
REQ-005 SHALL have port: Read_data_1  input  32  rs operand (multiplicand / dividend / mthi/mtlo source).
REQ-006 SHALL have port: Read_data_2  input  32  rt operand (multiplier / divisor).
REQ-007 SHALL have port: busy  output  1  high while an iterative operation is in progress.
REQ-008 SHALL have port: done  output  1  one-cycle pulse when HI/LO hold a new mult/div result.
REQ-009 SHALL have port: HI  output  32  HI register (product[63:32] / remainder).
REQ-010 SHALL have port: LO  output  32  LO register (product[31:0] / quotient).

Function
REQ-011 SHALL implement a 3-state FSM: IDLE, RUN, DONE.
REQ-012 IDLE + start + mult/multu/div/divu SHALL latch operands and opcode, clear 5-bit counter, go to RUN.
REQ-013 RUN SHALL perform one shift-add (multiply) or restoring subtract-shift (divide) step per cycle, on operand magnitudes for signed ops.
REQ-014 RUN SHALL last exactly 32 cycles (counter 0..31), then go to DONE.
REQ-015 HI/LO SHALL be written on the RUN->DONE edge; done=1 for exactly the DONE cycle; DONE->IDLE unconditionally.
REQ-016 busy SHALL be 1 in RUN and DONE, 0 in IDLE; start-to-done latency = 33 cycles.
REQ-017 Signed results SHALL be corrected after iteration: product negated if sign(rs)^sign(rt); quotient negated if sign(rs)^sign(rt); remainder takes sign of rs.
REQ-018 Divide by zero SHALL give LO=32'hFFFFFFFF, HI=rs (unsigned), and HI=rs, LO=32'hFFFFFFFF (signed); no exception, same latency.
REQ-019 Signed 32'h80000000 / 32'hFFFFFFFF SHALL give LO=32'h80000000, HI=0.
REQ-020 IDLE + start + mthi (mtlo) SHALL write Read_data_1 to HI (LO) on that edge, stay IDLE, no done pulse.
REQ-021 start while busy=1 SHALL be ignored; operands and result of the running operation unaffected.
REQ-022 start with any other Function_opcode SHALL be ignored.
REQ-023 HI/LO SHALL hold their value at all times except on writes per REQ-015/REQ-020; readable combinationally, including while busy (old value).

Reset
REQ-024 reset=0 SHALL asynchronously force state=IDLE, counter=0, busy=0, done=0, HI=0, LO=0, internal operand registers=0.
REQ-025 Reset during RUN/DONE SHALL abort the operation; no done pulse after reset release; first start after release SHALL be accepted.

Structure
REQ-026 Function-code constants (mult, multu, div, divu, mthi, mtlo) and FSM state encodings SHALL live in the shared CPU definitions package used by the decoder.
REQ-027 SHALL be a single module; no sub-module; one 64-bit working register pair plus 32-bit operand register, counter, FSM.

Verification
REQ-028 multu 0xFFFFFFFF x 0xFFFFFFFF -> done at cycle 33, HI=0xFFFFFFFE, LO=0x00000001.
REQ-029 mult 0xFFFFFFFD x 0x00000005 -> HI=0xFFFFFFFF, LO=0xFFFFFFF1; div 0xFFFFFFF9 / 0x00000002 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF.
REQ-030 divu 0x00000064 / 0 -> LO=0xFFFFFFFF, HI=0x00000064; div 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0.
REQ-031 divu 100/7 started, start with multu 2x3 at cycle 10 -> ignored, result LO=14, HI=2, single done pulse.
REQ-032 mult started, reset=0 at cycle 15 -> busy=0, HI=LO=0 immediately; no done; mtlo 0x12345678 after release -> LO=0x12345678 next edge, done stays 0.

Source files
------------

// File: rtl/multdiv32_pkg.sv
// Shared CPU definitions: function codes for HI/LO instructions and the multdiv FSM encoding.
// Pure declarations, no logic.
// Used by the decoder and by multdiv32.
package multdiv32_pkg;

    // R-type function codes (instruction[5:0]) that touch HI/LO
    localparam logic [5:0] FUNC_MULT  = 6'b011000;
    localparam logic [5:0] FUNC_MULTU = 6'b011001;
    localparam logic [5:0] FUNC_DIV   = 6'b011010;
    localparam logic [5:0] FUNC_DIVU  = 6'b011011;
    localparam logic [5:0] FUNC_MTHI  = 6'b010001;
    localparam logic [5:0] FUNC_MTLO  = 6'b010011;

    // Iteration count of the shift-add / subtract-shift loop
    localparam int unsigned MD_STEPS = 32;

    typedef enum logic [1:0] {
        MD_IDLE = 2'd0,
        MD_RUN  = 2'd1,
        MD_DONE = 2'd2
    } md_state_t;

    // True for the opcodes that start the iterative engine
    function automatic logic is_iter_op(input logic [5:0] func);
        return (func == FUNC_MULT) || (func == FUNC_MULTU) ||
               (func == FUNC_DIV)  || (func == FUNC_DIVU);
    endfunction

endpackage

// File: rtl/multdiv32.sv
// Iterative 32x32 multiply / divide unit with HI/LO registers and mthi/mtlo writes.
// Latency: start-to-done 33 cycles (32 RUN steps + DONE); mthi/mtlo write on the accepting edge.
// Backpressure: none; start is ignored while busy or for unrelated opcodes.
module multdiv32
    import multdiv32_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic [5:0]  Function_opcode,
    input  logic [31:0] Read_data_1,
    input  logic [31:0] Read_data_2,
    output logic        busy,
    output logic        done,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    md_state_t   state;
    md_state_t   state_nxt;
    logic [4:0]  cnt;

    // Working pair: multiply = {partial product, multiplier}, divide = {remainder, dividend/quotient}
    logic [31:0] wk_hi;
    logic [31:0] wk_lo;
    // Multiplicand or divisor magnitude
    logic [31:0] opnd;
    logic        op_div;
    logic        op_signed;
    logic        sign_rs;
    logic        sign_rt;

    logic [31:0] hi_q;
    logic [31:0] lo_q;

    logic        accept;
    logic        last_step;
    logic        is_div_in;
    logic        is_signed_in;
    logic [31:0] mag_rs;
    logic [31:0] mag_rt;

    assign accept       = (state == MD_IDLE) && start && is_iter_op(Function_opcode);
    assign last_step    = (state == MD_RUN) && (cnt == 5'd31);
    assign is_div_in    = (Function_opcode == FUNC_DIV) || (Function_opcode == FUNC_DIVU);
    assign is_signed_in = (Function_opcode == FUNC_MULT) || (Function_opcode == FUNC_DIV);
    assign mag_rs       = (is_signed_in && Read_data_1[31]) ? (32'd0 - Read_data_1) : Read_data_1;
    assign mag_rt       = (is_signed_in && Read_data_2[31]) ? (32'd0 - Read_data_2) : Read_data_2;

    // One iteration step of the multiply or restoring-divide loop
    logic [32:0] mul_sum;
    logic [32:0] div_part;
    logic        div_ge;
    logic [31:0] div_diff;
    logic [31:0] step_hi;
    logic [31:0] step_lo;

    always_comb begin
        mul_sum  = {1'b0, wk_hi} + (wk_lo[0] ? {1'b0, opnd} : 33'd0);
        div_part = {wk_hi, wk_lo[31]};
        div_ge   = (div_part >= {1'b0, opnd});
        // When div_ge holds the difference is below the divisor, so 32 bits suffice
        div_diff = div_part[31:0] - opnd;
        if (op_div) begin
            step_hi = div_ge ? div_diff : div_part[31:0];
            step_lo = {wk_lo[30:0], div_ge};
        end else begin
            step_hi = mul_sum[32:1];
            step_lo = {mul_sum[0], wk_lo[31:1]};
        end
    end

    // Sign correction of the final magnitudes; divisor zero forces an all-ones quotient
    logic        neg_res;
    logic [63:0] prod_mag;
    logic [63:0] prod_fix;
    logic [31:0] res_hi;
    logic [31:0] res_lo;

    always_comb begin
        neg_res  = op_signed && (sign_rs ^ sign_rt);
        prod_mag = {step_hi, step_lo};
        prod_fix = neg_res ? (64'd0 - prod_mag) : prod_mag;
        if (op_div) begin
            res_lo = (opnd == 32'd0) ? 32'hFFFF_FFFF :
                     (neg_res ? (32'd0 - step_lo) : step_lo);
            res_hi = (op_signed && sign_rs) ? (32'd0 - step_hi) : step_hi;
        end else begin
            res_lo = prod_fix[31:0];
            res_hi = prod_fix[63:32];
        end
    end

    // FSM state register
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state <= MD_IDLE;
        else        state <= state_nxt;
    end

    // FSM next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            MD_IDLE: if (accept) state_nxt = MD_RUN;
            MD_RUN:  if (cnt == 5'd31) state_nxt = MD_DONE;
            MD_DONE: state_nxt = MD_IDLE;
            default: state_nxt = MD_IDLE;
        endcase
    end

    // FSM outputs
    always_comb begin
        busy = (state == MD_RUN) || (state == MD_DONE);
        done = (state == MD_DONE);
    end

    // Operand latch, step counter and working registers
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cnt       <= 5'd0;
            wk_hi     <= 32'd0;
            wk_lo     <= 32'd0;
            opnd      <= 32'd0;
            op_div    <= 1'b0;
            op_signed <= 1'b0;
            sign_rs   <= 1'b0;
            sign_rt   <= 1'b0;
        end else if (accept) begin
            cnt       <= 5'd0;
            wk_hi     <= 32'd0;
            wk_lo     <= is_div_in ? mag_rs : mag_rt;
            opnd      <= is_div_in ? mag_rt : mag_rs;
            op_div    <= is_div_in;
            op_signed <= is_signed_in;
            sign_rs   <= Read_data_1[31];
            sign_rt   <= Read_data_2[31];
        end else if (state == MD_RUN) begin
            cnt       <= cnt + 5'd1;
            wk_hi     <= step_hi;
            wk_lo     <= step_lo;
        end
    end

    // HI/LO: written by the final step or by mthi/mtlo from IDLE, otherwise held
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            hi_q <= 32'd0;
            lo_q <= 32'd0;
        end else if (last_step) begin
            hi_q <= res_hi;
            lo_q <= res_lo;
        end else if ((state == MD_IDLE) && start) begin
            if (Function_opcode == FUNC_MTHI) hi_q <= Read_data_1;
            if (Function_opcode == FUNC_MTLO) lo_q <= Read_data_1;
        end
    end

    assign HI = hi_q;
    assign LO = lo_q;

endmodule

// File: tb/tb_multdiv32.sv
// Randomised and directed checks of multdiv32 against an arithmetic reference model.
// Inputs driven and outputs sampled on the falling clock edge.
// Every wait on done is bounded by a cycle budget.
module tb_multdiv32;
    import multdiv32_pkg::*;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [5:0]  Function_opcode = 6'd0;
    logic [31:0] Read_data_1 = 32'd0;
    logic [31:0] Read_data_2 = 32'd0;
    logic        busy;
    logic        done;
    logic [31:0] HI;
    logic [31:0] LO;

    int n_checks = 0;
    int n_fail   = 0;

    multdiv32 dut (
        .clock           (clock),
        .reset           (reset),
        .start           (start),
        .Function_opcode (Function_opcode),
        .Read_data_1     (Read_data_1),
        .Read_data_2     (Read_data_2),
        .busy            (busy),
        .done            (done),
        .HI              (HI),
        .LO              (LO)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference: plain 64-bit arithmetic on the architectural definition of each instruction
    task automatic model(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] hi, output logic [31:0] lo);
        longint          sa, sb, sp, sq, sr;
        longint unsigned ua, ub, up;
        logic [63:0]     w;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = longint'(a);
        ub = longint'(b);
        hi = 32'd0;
        lo = 32'd0;
        if (op == FUNC_MULT) begin
            sp = sa * sb;
            w  = sp;
            hi = w[63:32];
            lo = w[31:0];
        end else if (op == FUNC_MULTU) begin
            up = ua * ub;
            w  = up;
            hi = w[63:32];
            lo = w[31:0];
        end else if (b == 32'd0) begin
            hi = a;
            lo = 32'hFFFF_FFFF;
        end else if (op == FUNC_DIV) begin
            sq = sa / sb;
            sr = sa % sb;
            w  = sq;
            lo = w[31:0];
            w  = sr;
            hi = w[31:0];
        end else begin
            up = ua / ub;
            w  = up;
            lo = w[31:0];
            up = ua % ub;
            w  = up;
            hi = w[31:0];
        end
    endtask

    // Issue one iterative op and check latency, held HI/LO while busy, result and done width
    task automatic run_op(input string tag, input logic [5:0] op, input logic [31:0] a,
                          input logic [31:0] b);
        logic [31:0] ehi, elo, old_hi, old_lo;
        int n;
        model(op, a, b, ehi, elo);
        @(negedge clock);
        old_hi = HI;
        old_lo = LO;
        start = 1'b1;
        Function_opcode = op;
        Read_data_1 = a;
        Read_data_2 = b;
        @(negedge clock);
        start = 1'b0;
        n = 1;
        while (!done && n < 40) begin
            if (n == 16) begin
                check({tag, " busy_mid"}, {63'd0, busy}, 64'd1);
                check({tag, " hold_mid"}, {HI, LO}, {old_hi, old_lo});
            end
            @(negedge clock);
            n++;
        end
        check({tag, " latency"}, 64'(n), 64'd33);
        check({tag, " result"}, {HI, LO}, {ehi, elo});
        @(negedge clock);
        check({tag, " done_pulse"}, {62'd0, done, busy}, 64'd0);
    endtask

    initial begin
        logic [5:0]  ops [4];
        logic [31:0] a, b;
        int pulses;
        ops[0] = FUNC_MULT;
        ops[1] = FUNC_MULTU;
        ops[2] = FUNC_DIV;
        ops[3] = FUNC_DIVU;

        #1;
        check("reset_state", {busy, done, HI, LO}, 66'd0);
        repeat (2) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        check("idle_after_reset", {busy, done, HI, LO}, 66'd0);

        // Directed vectors
        run_op("multu_max", FUNC_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        check("multu_max_val", {HI, LO}, 64'hFFFF_FFFE_0000_0001);
        run_op("mult_neg", FUNC_MULT, 32'hFFFF_FFFD, 32'h0000_0005);
        check("mult_neg_val", {HI, LO}, 64'hFFFF_FFFF_FFFF_FFF1);
        run_op("div_neg", FUNC_DIV, 32'hFFFF_FFF9, 32'h0000_0002);
        check("div_neg_val", {HI, LO}, 64'hFFFF_FFFF_FFFF_FFFD);
        run_op("divu_zero", FUNC_DIVU, 32'h0000_0064, 32'h0);
        check("divu_zero_val", {HI, LO}, 64'h0000_0064_FFFF_FFFF);
        run_op("div_zero_neg", FUNC_DIV, 32'hFFFF_FF00, 32'h0);
        check("div_zero_neg_val", {HI, LO}, 64'hFFFF_FF00_FFFF_FFFF);
        run_op("div_ovf", FUNC_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
        check("div_ovf_val", {HI, LO}, 64'h0000_0000_8000_0000);
        run_op("div_rem_sign", FUNC_DIV, 32'h0000_0007, 32'hFFFF_FFFE);
        check("div_rem_sign_val", {HI, LO}, 64'h0000_0001_FFFF_FFFD);

        // Randomised operations
        for (int i = 0; i < 40; i++) begin
            a = $urandom;
            b = $urandom;
            case ($urandom_range(0, 5))
                0: b = 32'd0;
                1: b = $urandom_range(1, 9);
                2: a = $urandom_range(0, 1000);
                default: ;
            endcase
            run_op($sformatf("rand%0d", i), ops[$urandom_range(0, 3)], a, b);
        end

        // start while busy is ignored: divu 100/7 with multu 2x3 injected at cycle 10
        @(negedge clock);
        start = 1'b1;
        Function_opcode = FUNC_DIVU;
        Read_data_1 = 32'd100;
        Read_data_2 = 32'd7;
        @(negedge clock);
        start = 1'b0;
        pulses = 0;
        for (int n = 1; n < 45; n++) begin
            if (done) pulses++;
            if (n == 10) begin
                start = 1'b1;
                Function_opcode = FUNC_MULTU;
                Read_data_1 = 32'd2;
                Read_data_2 = 32'd3;
            end else begin
                start = 1'b0;
            end
            @(negedge clock);
        end
        check("busy_ignore_pulses", 64'(pulses), 64'd1);
        check("busy_ignore_val", {HI, LO}, {32'd2, 32'd14});

        // Unknown opcode is ignored
        @(negedge clock);
        start = 1'b1;
        Function_opcode = 6'b100000;
        Read_data_1 = 32'hDEAD_BEEF;
        @(negedge clock);
        start = 1'b0;
        check("bad_op_ignored", {busy, done, HI, LO}, {2'b00, 32'd2, 32'd14});

        // mthi writes HI only, no busy or done
        start = 1'b1;
        Function_opcode = FUNC_MTHI;
        Read_data_1 = 32'hCAFE_0001;
        @(negedge clock);
        start = 1'b0;
        check("mthi", {busy, done, HI, LO}, {2'b00, 32'hCAFE_0001, 32'd14});

        // Reset mid-operation aborts; mtlo after release
        start = 1'b1;
        Function_opcode = FUNC_MULT;
        Read_data_1 = 32'h1234;
        Read_data_2 = 32'h5678;
        @(negedge clock);
        start = 1'b0;
        repeat (14) @(negedge clock);
        reset = 1'b0;
        #1;
        check("abort_state", {busy, done, HI, LO}, 66'd0);
        @(negedge clock);
        reset = 1'b1;
        pulses = 0;
        for (int n = 0; n < 40; n++) begin
            @(negedge clock);
            if (done || busy) pulses++;
        end
        check("abort_no_done", 64'(pulses), 64'd0);
        start = 1'b1;
        Function_opcode = FUNC_MTLO;
        Read_data_1 = 32'h1234_5678;
        @(negedge clock);
        start = 1'b0;
        check("mtlo_after_reset", {busy, done, HI, LO}, {2'b00, 32'd0, 32'h1234_5678});

        // First iterative start after reset is accepted
        run_op("post_reset_op", FUNC_MULTU, 32'd6, 32'd7);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
